dekatron_burst_driver: RTL and testbench

//  Command sequencer directly upstream of the dekatron counter: accepts one burst command
//  (INC/DEC by N steps, SET, SET_ZERO) and drives the counter's Request/Dec/Set/SetZero/In.

---
 rtl/dekatron_burst_driver.sv | 132 +++++++++++++
 tb/tb_dekatron_burst_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dekatron_burst_driver.sv
// Burst command sequencer for the dekatron counter (INC/DEC by N, SET, SET_ZERO).
// Optional BURST_STOP_ON_ZERO_EN: DEC bursts stop early when the counter reaches zero.
module dekatron_burst_driver #(
    parameter int WIDTH   = 12,
    parameter int STEP_W  = 8,
    parameter int GUARD   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [1:0]        CmdOp,
    input  logic [STEP_W-1:0] CmdSteps,
    input  logic [WIDTH-1:0]  CmdData,
    output logic              Request,
    output logic              Dec,
    output logic              Set,
    output logic              SetZero,
    output logic [WIDTH-1:0]  In,
    input  logic              CntReady,
    input  logic              CntZero,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [STEP_W-1:0] StepsDone
);

    localparam int GW = $clog2(GUARD + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [STEP_W-1:0] remaining;
    logic [GW-1:0]     guard_cnt;
    logic [7:0]        wait_cnt;
    logic              zero_seen;

`ifdef BURST_STOP_ON_ZERO_EN
    assign zero_seen = CntZero;
`else
    assign zero_seen = CntZero & 1'b0;
`endif

    assign CmdReady = (state == S_IDLE);
    assign Busy     = (state != S_IDLE);

    // Request and Done lag their state by one cycle; GUARD counts from Request's fall.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            guard_cnt <= '0;
            wait_cnt  <= '0;
            Request   <= 1'b0;
            Dec       <= 1'b0;
            Set       <= 1'b0;
            SetZero   <= 1'b0;
            In        <= '0;
            Done      <= 1'b0;
            Error     <= 1'b0;
            StepsDone <= '0;
        end else begin
            Request <= 1'b0;
            Done    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (CmdValid) begin
                        Dec       <= (CmdOp == 2'b01);
                        Set       <= (CmdOp == 2'b10);
                        SetZero   <= (CmdOp == 2'b11);
                        In        <= CmdData;
                        StepsDone <= '0;
                        Error     <= 1'b0;
                        if (CmdOp[1]) begin
                            remaining <= STEP_W'(1);
                            state     <= S_ISSUE;
                        end else begin
                            remaining <= CmdSteps;
                            if (CmdSteps == '0 || (CmdOp[0] && zero_seen))
                                state <= S_DONE;
                            else
                                state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    Request   <= 1'b1;
                    remaining <= remaining - 1'b1;
                    StepsDone <= StepsDone + 1'b1;
                    guard_cnt <= '0;
                    state     <= S_GUARD;
                end
                S_GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (CntReady) begin
                        if (remaining == '0 || (Dec && zero_seen))
                            state <= S_DONE;
                        else
                            state <= S_ISSUE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        Error <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    Done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dekatron_burst_driver.sv
// Directed bench for dekatron_burst_driver with a behavioural decimal counter model.
// Counter answers Ready four cycles after each Request unless held.
module tb_dekatron_burst_driver;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        CmdValid = 1'b0;
    logic        CmdReady;
    logic [1:0]  CmdOp = 2'b00;
    logic [7:0]  CmdSteps = 8'd0;
    logic [11:0] CmdData = 12'h000;
    logic        Request, Dec, Set, SetZero, Busy, Done, Error;
    logic [11:0] In;
    logic        CntReady = 1'b1;
    logic        CntZero;
    logic [7:0]  StepsDone;

    int checks = 0;
    int failures = 0;
    int val = 0;
    int dly = 0;
    int mreq = 0;
    bit hold = 1'b0;
    int req_cnt = 0;
    int done_cnt = 0;
    int viol = 0;
    bit prev_req = 1'b0;
    int n;

    always #5 Clk = ~Clk;

    assign CntZero = (val == 0);

    dekatron_burst_driver dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdOp(CmdOp), .CmdSteps(CmdSteps), .CmdData(CmdData),
        .Request(Request), .Dec(Dec), .Set(Set), .SetZero(SetZero),
        .In(In), .CntReady(CntReady), .CntZero(CntZero),
        .Busy(Busy), .Done(Done), .Error(Error), .StepsDone(StepsDone)
    );

    // Counter model
    always @(negedge Clk) begin
        if (Request) begin
            CntReady = 1'b0;
            mreq++;
            dly = (hold && mreq == 2) ? -1 : 4;
        end else if (dly < 0) begin
            if (!hold) begin
                CntReady = 1'b1;
                dly = 0;
            end
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                if (SetZero) val = 0;
                else if (Set) val = In[11:8] * 100 + In[7:4] * 10 + In[3:0];
                else if (Dec) val = (val + 999) % 1000;
                else val = (val + 1) % 1000;
                CntReady = 1'b1;
            end
        end
    end

    always @(negedge Clk) begin
        if (Request) req_cnt++;
        if (Done) done_cnt++;
        if (Request && prev_req) viol++;
        prev_req = Request;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] st, input logic [11:0] d);
        @(negedge Clk);
        CmdOp = op;
        CmdSteps = st;
        CmdData = d;
        CmdValid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        CmdValid = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        while (!Done && cyc < maxc) begin
            @(negedge Clk);
            cyc++;
        end
    endtask

    task automatic clear_counts();
        req_cnt = 0;
        done_cnt = 0;
        mreq = 0;
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("rst_ready", 32'(CmdReady), 1);
        check("rst_busy", 32'(Busy), 0);
        check("rst_req", 32'(Request), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_err", 32'(Error), 0);
        check("rst_in", 32'(In), 0);
        check("rst_steps", 32'(StepsDone), 0);

        // INC 5 with ignored CmdValid while busy
        clear_counts();
        send(2'b00, 8'd5, 12'h000);
        CmdOp = 2'b10;
        CmdData = 12'h777;
        CmdValid = 1'b1;
        repeat (5) @(negedge Clk);
        CmdValid = 1'b0;
        wait_done(200, n);
        check("inc5_done_seen", 32'(Done), 1);
        check("inc5_busy_at_done", 32'(Busy), 0);
        check("inc5_ready_at_done", 32'(CmdReady), 1);
        check("inc5_steps", 32'(StepsDone), 5);
        check("inc5_val", 32'(val), 5);
        repeat (3) @(negedge Clk);
        check("inc5_reqs", 32'(req_cnt), 5);
        check("inc5_done_once", 32'(done_cnt), 1);
        check("inc5_set_low", 32'(Set), 0);

        // SET 123 with CmdSteps ignored
        clear_counts();
        send(2'b10, 8'd9, 12'h123);
        check("set_held", 32'(Set), 1);
        check("set_dec_low", 32'(Dec), 0);
        check("set_in", 32'(In), 32'h123);
        wait_done(200, n);
        check("set_held_end", 32'(Set), 1);
        check("set_steps", 32'(StepsDone), 1);
        repeat (2) @(negedge Clk);
        check("set_reqs", 32'(req_cnt), 1);
        check("set_val", 32'(val), 123);

        // INC 0: Done two cycles after accept, no Request
        clear_counts();
        send(2'b00, 8'd0, 12'h000);
        check("inc0_busy", 32'(Busy), 1);
        check("inc0_done_early", 32'(Done), 0);
        @(negedge Clk);
        check("inc0_done", 32'(Done), 1);
        check("inc0_busy_off", 32'(Busy), 0);
        check("inc0_steps", 32'(StepsDone), 0);
        @(negedge Clk);
        check("inc0_done_pulse", 32'(Done), 0);
        check("inc0_reqs", 32'(req_cnt), 0);

        // DEC 3 from 001
        send(2'b10, 8'd0, 12'h001);
        wait_done(200, n);
        check("pre_dec_val", 32'(val), 1);
        clear_counts();
        send(2'b01, 8'd3, 12'h000);
        check("dec_held", 32'(Dec), 1);
        wait_done(200, n);
        repeat (2) @(negedge Clk);
`ifdef BURST_STOP_ON_ZERO_EN
        check("dec_reqs", 32'(req_cnt), 1);
        check("dec_steps", 32'(StepsDone), 1);
        check("dec_val", 32'(val), 0);
`else
        check("dec_reqs", 32'(req_cnt), 3);
        check("dec_steps", 32'(StepsDone), 3);
        check("dec_val", 32'(val), 998);
`endif

        // Timeout: counter never answers the second Request
        clear_counts();
        hold = 1'b1;
        send(2'b00, 8'd5, 12'h000);
        wait_done(400, n);
        check("to_done_seen", 32'(Done), 1);
        check("to_error", 32'(Error), 1);
        check("to_steps", 32'(StepsDone), 2);
        check("to_latency", 32'(n >= 258 && n <= 275), 1);
        hold = 1'b0;
        repeat (3) @(negedge Clk);
        check("to_reqs", 32'(req_cnt), 2);
        check("to_error_sticky", 32'(Error), 1);
        check("to_ready_back", 32'(CntReady), 1);
        send(2'b00, 8'd1, 12'h000);
        check("to_error_cleared", 32'(Error), 0);
        wait_done(200, n);
        check("after_to_steps", 32'(StepsDone), 1);

        // Reset during GUARD of step 3 of 7
        @(negedge Clk);
        clear_counts();
        send(2'b00, 8'd7, 12'h000);
        n = 0;
        while (StepsDone != 8'd3 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("rst_mid_reached", 32'(StepsDone), 3);
        Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        check("rst_mid_req", 32'(Request), 0);
        check("rst_mid_busy", 32'(Busy), 0);
        check("rst_mid_ready", 32'(CmdReady), 1);
        check("rst_mid_steps", 32'(StepsDone), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (20) @(negedge Clk);
        check("rst_mid_no_done", 32'(done_cnt), 0);
        check("rst_mid_idle", 32'(Busy), 0);

        check("req_never_back_to_back", 32'(viol), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
